// File: rtl/register_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// register_scoreboard_pkg
// Shared pipeline definitions for the issue scoreboard:
//   issue_kind_e  - decoded instruction class presented at issue
//   stall_cause_e - reason reported alongside a decode stall
//   pick_cause    - priority encoder for the stall cause
// ---------------------------------------------------------------------------
package register_scoreboard_pkg;

   localparam int NUM_ARCH_REGS = 32;

   typedef enum logic [1:0] {
      KIND_ALU  = 2'b00,
      KIND_LOAD = 2'b01,
      KIND_LONG = 2'b10,
      KIND_RSVD = 2'b11   // decoded as an ALU op: never creates busy state
   } issue_kind_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_LOAD_USE = 2'b01,
      CAUSE_LONG_DEP = 2'b10,   // RAW on the long result, or WAW on its RD
      CAUSE_LONG_OCC = 2'b11    // second long op while the unit is busy
   } stall_cause_e;

   // Load-use outranks a long dependency, which outranks unit occupancy.
   function automatic stall_cause_e pick_cause(input logic load_use,
                                               input logic long_dep,
                                               input logic long_occ);
      stall_cause_e cause;
      cause = CAUSE_NONE;
      if (load_use)
         cause = CAUSE_LOAD_USE;
      else if (long_dep)
         cause = CAUSE_LONG_DEP;
      else if (long_occ)
         cause = CAUSE_LONG_OCC;
      return cause;
   endfunction

endpackage

// File: rtl/load_pending_queue.sv
// ---------------------------------------------------------------------------
// load_pending_queue
// Fixed-length delay line of {valid, rd} entries. A pushed entry shifts one
// stage per cycle and drops off the end after DEPTH cycles; while it is in
// the line its register is reported in busy_mask. Flush invalidates all
// entries at the next edge.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - invalidate every entry
//   push_valid   - enter push_rd into the first stage this cycle
//   push_rd      - destination register of the load
//   busy_mask    - one bit per architectural register held by an entry
// ---------------------------------------------------------------------------
module load_pending_queue
   import register_scoreboard_pkg::*;
#(
   parameter int DEPTH     = 1,
   parameter int REG_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push_valid,
   input  logic [REG_WIDTH-1:0]     push_rd,
   output logic [NUM_ARCH_REGS-1:0] busy_mask
);

   logic                 valid_reg [DEPTH];
   logic [REG_WIDTH-1:0] rd_reg    [DEPTH];
   logic                 src_valid [DEPTH];
   logic [REG_WIDTH-1:0] src_rd    [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign src_valid[gi] = push_valid;
            assign src_rd[gi]    = push_rd;
         end else begin : g_body
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_rd[gi]    = rd_reg[gi-1];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg[gi] <= 1'b0;
               rd_reg[gi]    <= '0;
            end else if (flush) begin
               valid_reg[gi] <= 1'b0;
               rd_reg[gi]    <= '0;
            end else begin
               valid_reg[gi] <= src_valid[gi];
               rd_reg[gi]    <= src_rd[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_reg[i])
            busy_mask[rd_reg[i]] = 1'b1;
      end
   end

endmodule

// File: rtl/register_scoreboard.sv
// ---------------------------------------------------------------------------
// register_scoreboard
// Decode-stage hazard detector for an in-order pipeline with one LOAD delay
// line (LOAD_LATENCY deep, 1..3) and a single blocking long (mul/div) unit.
// Ports:
//   i_Clock, i_Reset        - clock, asynchronous active-low reset
//   i_IssueValid            - instruction presented at decode
//   i_IssueRD/RDEnable      - destination register and its write enable
//   i_IssueKind             - ALU / LOAD / LONG / reserved (as ALU)
//   i_IssueRS1/RS2, *Used   - source registers and whether they are read
//   i_LongDone              - long unit delivers its result this cycle
//   i_Flush                 - squash current issue and pending loads
//   o_Stall, o_StallCause   - combinational hold of decode and its reason
//   o_BusyMask              - registers with a non-forwardable pending write
//   o_LongBusy              - long operation outstanding
//   o_StallCount            - saturating count of stalled cycles
// ---------------------------------------------------------------------------
module register_scoreboard
   import register_scoreboard_pkg::*;
#(
   parameter int REG_WIDTH    = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     i_IssueValid,
   input  logic [REG_WIDTH-1:0]     i_IssueRD,
   input  logic                     i_IssueRDEnable,
   input  logic [1:0]               i_IssueKind,
   input  logic [REG_WIDTH-1:0]     i_IssueRS1,
   input  logic [REG_WIDTH-1:0]     i_IssueRS2,
   input  logic                     i_IssueRS1Used,
   input  logic                     i_IssueRS2Used,
   input  logic                     i_LongDone,
   input  logic                     i_Flush,
   output logic                     o_Stall,
   output logic [1:0]               o_StallCause,
   output logic [NUM_ARCH_REGS-1:0] o_BusyMask,
   output logic                     o_LongBusy,
   output logic [COUNT_WIDTH-1:0]   o_StallCount
);

   issue_kind_e              kind;
   logic [NUM_ARCH_REGS-1:0] load_mask;
   logic [NUM_ARCH_REGS-1:0] long_mask;
   logic                     long_busy_reg;
   logic [REG_WIDTH-1:0]     long_rd_reg;
   logic [COUNT_WIDTH-1:0]   count_reg;
   logic                     rs1_live, rs2_live, rd_live;
   logic                     load_use, long_dep, long_occ;
   logic                     accept, load_push, long_start;
   stall_cause_e             cause;

   assign kind = issue_kind_e'(i_IssueKind);

   // x0 is hardwired, so it is never a live operand or destination.
   assign rs1_live = i_IssueRS1Used  && (i_IssueRS1 != '0);
   assign rs2_live = i_IssueRS2Used  && (i_IssueRS2 != '0);
   assign rd_live  = i_IssueRDEnable && (i_IssueRD  != '0);

   assign load_use = (rs1_live && load_mask[i_IssueRS1]) ||
                     (rs2_live && load_mask[i_IssueRS2]);
   // long_rd_reg is never x0 while busy, so the live gating covers x0 too.
   // i_LongDone is deliberately not consulted: no done-to-decode bypass.
   assign long_dep = long_busy_reg &&
                     ((rs1_live && (i_IssueRS1 == long_rd_reg)) ||
                      (rs2_live && (i_IssueRS2 == long_rd_reg)) ||
                      (rd_live  && (i_IssueRD  == long_rd_reg)));
   assign long_occ = long_busy_reg && (kind == KIND_LONG);

   assign o_Stall      = i_IssueValid && (load_use || long_dep || long_occ);
   assign cause        = o_Stall ? pick_cause(load_use, long_dep, long_occ) : CAUSE_NONE;
   assign o_StallCause = cause;

   assign accept     = i_IssueValid && !o_Stall && !i_Flush;
   assign load_push  = accept && (kind == KIND_LOAD) && rd_live;
   assign long_start = accept && (kind == KIND_LONG) && rd_live;

   load_pending_queue #(
      .DEPTH     (LOAD_LATENCY),
      .REG_WIDTH (REG_WIDTH)
   ) u_load_queue (
      .clk        (i_Clock),
      .rst_n      (i_Reset),
      .flush      (i_Flush),
      .push_valid (load_push),
      .push_rd    (i_IssueRD),
      .busy_mask  (load_mask)
   );

   // long_start requires !long_busy_reg (occupancy stalls), so a done and a
   // start never collide on the same edge.
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         long_busy_reg <= 1'b0;
         long_rd_reg   <= '0;
      end else if (i_LongDone && long_busy_reg) begin
         long_busy_reg <= 1'b0;
         long_rd_reg   <= '0;
      end else if (long_start) begin
         long_busy_reg <= 1'b1;
         long_rd_reg   <= i_IssueRD;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_long_mask
         assign long_mask[gi] = long_busy_reg && (long_rd_reg == REG_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset)
         count_reg <= '0;
      else if (o_Stall && (count_reg != '1))
         count_reg <= count_reg + 1'b1;
   end

   assign o_BusyMask   = load_mask | long_mask;
   assign o_LongBusy   = long_busy_reg;
   assign o_StallCount = count_reg;

endmodule
